branch_resolver: RTL
====================

// Module: branch_resolver
// PURPOSE
//  Resolution-side partner of the fetch-stage BTB lookup. Fetch enqueues each fetched instr's prediction
//  (pc, BTB hit, predicted target) into an in-order tracking FIFO. At resolution (MEM stage), the oldest
//  record is popped and compared against the actual outcome. Mispredicts drive a redirect/flush pulse.
//  Taken branches with a missing/wrong target drive the BTB write port (load, br_pc_in, br_target_pc).
// PARAMETERS
//  DEPTH  4   in-flight prediction records (power of 2, >=2)
//  CNT_W  16  width of saturating statistics counters
// PORTS
//  clk             in   1      single clock, all state on rising edge
//  rst_n           in   1      asynchronous, active-low reset
//  fetch_valid     in   1      push prediction record this cycle
//  fetch_pc        in   16     lc3b_word, pc of fetched instr
//  pred_taken      in   1      BTB hit at fetch
//  pred_target     in   16     BTB target at fetch
//  fifo_full       out  1      no free record; fetch must stall
//  resolve_valid   in   1      oldest in-flight instr resolved this cycle
//  is_branch       in   1      resolved instr is BR/JMP/JSR/TRAP
//  actual_taken    in   1      resolved control transfer taken
//  actual_target   in   16     resolved target pc
//  redirect        out  1      1-cycle pulse: fetch restarts at redirect_pc; younger instrs squashed
//  redirect_pc     out  16     correct next pc
//  btb_load        out  1      1-cycle BTB write strobe
//  btb_br_pc       out  16     pc written to BTB
//  btb_target      out  16     target written to BTB
//  branch_count    out  CNT_W  resolved branches, saturating
//  mispredict_cnt  out  CNT_W  redirects issued, saturating
//  protocol_err    out  1      sticky: push when full or pop when empty
// BEHAVIOUR
//  Reset: FIFO empty (ptrs 0, count 0), state RUN, all outputs 0.
//  FIFO: circular buffer, count 0..DEPTH. fifo_full = (count==DEPTH), combinational from count.
//  Simultaneous push+pop when full: both accepted, count unchanged.
//  Pop: resolve_valid in RUN pops head. resolve_valid when empty: ignored, protocol_err<=1.
//  Push: fetch_valid in RUN when full with no pop: dropped, protocol_err<=1.
//  Mispredict (head H, all compares in resolve cycle N):
//    (H.pred_taken != actual_taken) || (actual_taken && H.pred_target != actual_target).
//    Non-branch with H.pred_taken=1 (aliased BTB hit) is a mispredict with actual_taken treated as 0.
//  Next pc: actual_taken ? actual_target : H.pc + 16'd2 (wraps mod 2^16).
//  FSM: RUN, FLUSH.
//    RUN -> FLUSH on mispredict in cycle N. At edge ending N: FIFO cleared entirely (same-cycle push
//    discarded), redirect<=1, redirect_pc<=next pc, mispredict_cnt++.
//    FLUSH lasts exactly 1 cycle (N+1). fetch_valid and resolve_valid ignored (no err). -> RUN.
//    First correct-path push is accepted in N+2.
//  BTB update: is_branch && actual_taken && (!H.pred_taken || H.pred_target != actual_target).
//    Registered: btb_load pulses in N+1 with btb_br_pc=H.pc, btb_target=actual_target.
//    Independent of redirect; both may pulse in the same cycle. Not-taken branches never write the BTB.
//  branch_count++ on every popped record with is_branch=1. Both counters saturate at all-ones.
//  redirect/btb_load are registered 1-cycle pulses, 0 otherwise; redirect_pc/btb_* hold last value.
//  rst_n low at any time (incl. FLUSH): immediate return to reset state.
// STRUCTURE
//  lc3b_types: lc3b_word; add typedef struct {lc3b_word pc; logic taken; lc3b_word target;} lc3b_bpred
//  and enum br_res_state_t {BR_RUN, BR_FLUSH}.
//  Sub-module: bpred_fifo (DEPTH-parameterized storage, push/pop/clear, count, full/empty).
//  Top holds the compare logic, FSM, output registers and counters.
// TESTING
//  1 push {pc=x3000,taken=0}; resolve is_branch=1,taken=0 -> no redirect, no btb_load, branch_count=1.
//  2 push {x3000,0}; resolve taken=1,target=x3040 -> N+1: redirect=1, redirect_pc=x3040, btb_load=1,
//    btb_br_pc=x3000, btb_target=x3040; FIFO empty; mispredict_cnt=1.
//  3 push {x3010,1,x3100}; resolve taken=0 -> redirect_pc=x3012, btb_load=0.
//  4 push 4 records -> fifo_full=1; 5th push with no pop -> dropped, protocol_err=1;
//    push+pop same cycle while full -> count stays 4.
//  5 push {x3020,1,x3100}, 2 younger records; resolve taken=1,target=x3200 with same-cycle push ->
//    redirect_pc=x3200, btb_target=x3200, FIFO empty. Push in N+1 ignored; push in N+2 accepted.
//  6 drive mispredict, assert rst_n=0 during FLUSH -> all outputs 0, count 0, state RUN immediately.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b branch prediction / resolution path.
//   lc3b_word      : 16-bit machine word (pc, targets)
//   lc3b_bpred     : prediction record captured at fetch {pc, taken, target}
//   br_res_state_t : resolver FSM states
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        lc3b_word pc;
        logic     taken;
        lc3b_word target;
    } lc3b_bpred;

    typedef enum logic {
        BR_RUN   = 1'b0,
        BR_FLUSH = 1'b1
    } br_res_state_t;

    // Fall-through distance of one LC-3b instruction.
    localparam lc3b_word PC_STEP = 16'd2;

endpackage

// File: rtl/bpred_fifo.sv
// In-order circular buffer of prediction records between fetch and resolve.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail (taken when not full, or when
//                 a pop happens in the same cycle)
//   push_data   : record to store
//   pop         : retire the head record (ignored when empty)
//   clear       : discard all records; overrides push and pop
//   head        : oldest record, valid while !empty
//   full, empty : occupancy flags, combinational from the count
module bpred_fifo
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  lc3b_bpred push_data,
    input  logic      pop,
    input  logic      clear,
    output lc3b_bpred head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_W + 1;

    lc3b_bpred            mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]  count_q,  count_d;
    logic                 do_push, do_pop;

    assign full    = (count_q == CNT_BITS'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];

    // When full, a push is still legal if the head leaves in the same cycle:
    // the tail slot being written is the one the head vacates.
    assign do_push = push && (!full || pop) && !clear;
    assign do_pop  = pop && !empty && !clear;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: record storage is deliberately not reset; count_q alone decides
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolution-side partner of the fetch-stage BTB lookup.
// Fetch pushes one prediction record per fetched instruction; at resolution
// the oldest record is compared with the real outcome. A mispredict flushes
// all in-flight records and pulses redirect; a taken branch whose target the
// BTB lacked or got wrong pulses btb_load.
//   fetch_valid/fetch_pc/pred_taken/pred_target : push a prediction record
//   fifo_full        : no free record, fetch must stall
//   resolve_valid/is_branch/actual_taken/actual_target : head outcome
//   redirect/redirect_pc : 1-cycle restart pulse and the correct next pc
//   btb_load/btb_br_pc/btb_target : 1-cycle BTB write strobe and data
//   branch_count/mispredict_cnt   : saturating statistics
//   protocol_err     : sticky, push while full or pop while empty
module branch_resolver
    import lc3b_types::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    input  logic [15:0]      fetch_pc,
    input  logic             pred_taken,
    input  logic [15:0]      pred_target,
    output logic             fifo_full,
    input  logic             resolve_valid,
    input  logic             is_branch,
    input  logic             actual_taken,
    input  logic [15:0]      actual_target,
    output logic             redirect,
    output logic [15:0]      redirect_pc,
    output logic             btb_load,
    output logic [15:0]      btb_br_pc,
    output logic [15:0]      btb_target,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic             protocol_err
);

    br_res_state_t    state_q, state_d;
    logic             run_mode;

    lc3b_bpred        head;
    lc3b_bpred        push_rec;
    logic             fifo_empty;

    logic             push_req, pop_req;
    logic             eff_taken, mispredict, btb_update, err_set;
    lc3b_word         next_pc;

    logic             redirect_q,     redirect_d;
    lc3b_word         redirect_pc_q,  redirect_pc_d;
    logic             btb_load_q,     btb_load_d;
    lc3b_word         btb_br_pc_q,    btb_br_pc_d;
    lc3b_word         btb_target_q,   btb_target_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_q,   mispredict_d;
    logic             protocol_err_q, protocol_err_d;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BR_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BR_RUN:   if (mispredict) state_d = BR_FLUSH;
            BR_FLUSH: state_d = BR_RUN;
            default:  state_d = BR_RUN;
        endcase
    end

    // FLUSH is the single cycle in which squashed fetch/resolve traffic is
    // still on the wires; it is ignored outright rather than flagged.
    always_comb begin
        run_mode = (state_q == BR_RUN);
    end

    // ---------------- tracking FIFO ----------------
    assign push_rec = '{pc: fetch_pc, taken: pred_taken, target: pred_target};
    assign push_req = run_mode && fetch_valid;
    assign pop_req  = run_mode && resolve_valid && !fifo_empty;

    bpred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (push_rec),
        .pop       (pop_req),
        .clear     (mispredict),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------- resolution compare ----------------
    // A non-branch never transfers control, so an aliased BTB hit on it is
    // judged against "not taken".
    assign eff_taken  = is_branch && actual_taken;
    assign mispredict = pop_req &&
                        ((head.taken != eff_taken) ||
                         (eff_taken && (head.target != actual_target)));
    assign btb_update = pop_req && eff_taken &&
                        (!head.taken || (head.target != actual_target));
    assign next_pc    = eff_taken ? actual_target : lc3b_word'(head.pc + PC_STEP);
    assign err_set    = run_mode &&
                        ((resolve_valid && fifo_empty) ||
                         (fetch_valid && fifo_full && !pop_req));

    always_comb begin
        redirect_d     = mispredict;
        redirect_pc_d  = redirect_pc_q;
        btb_load_d     = btb_update;
        btb_br_pc_d    = btb_br_pc_q;
        btb_target_d   = btb_target_q;
        branch_count_d = branch_count_q;
        mispredict_d   = mispredict_q;
        protocol_err_d = protocol_err_q | err_set;

        if (mispredict) begin
            redirect_pc_d = next_pc;
            if (mispredict_q != '1) mispredict_d = mispredict_q + 1'b1;
        end
        if (btb_update) begin
            btb_br_pc_d  = head.pc;
            btb_target_d = actual_target;
        end
        if (pop_req && is_branch && (branch_count_q != '1))
            branch_count_d = branch_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q     <= 1'b0;
            redirect_pc_q  <= '0;
            btb_load_q     <= 1'b0;
            btb_br_pc_q    <= '0;
            btb_target_q   <= '0;
            branch_count_q <= '0;
            mispredict_q   <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            redirect_q     <= redirect_d;
            redirect_pc_q  <= redirect_pc_d;
            btb_load_q     <= btb_load_d;
            btb_br_pc_q    <= btb_br_pc_d;
            btb_target_q   <= btb_target_d;
            branch_count_q <= branch_count_d;
            mispredict_q   <= mispredict_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign btb_load       = btb_load_q;
    assign btb_br_pc      = btb_br_pc_q;
    assign btb_target     = btb_target_q;
    assign branch_count   = branch_count_q;
    assign mispredict_cnt = mispredict_q;
    assign protocol_err   = protocol_err_q;

endmodule
